// File: rtl/tick_pkg.sv
// Shared definitions for the fractional-N tick generator.
//   DIV_W / FRAC_W / SUB_W : default field widths
//   DEFAULT_DIV            : integer divider after reset (period = DIV+1)
//   tick_cfg_t             : {div_int, div_frac}, used for shadow and active config
package tick_pkg;

   localparam int DIV_W       = 10;
   localparam int FRAC_W      = 8;
   localparam int SUB_W       = 8;
   localparam int DEFAULT_DIV = 999;

   typedef struct packed {
      logic [DIV_W-1:0]  div_int;
      logic [FRAC_W-1:0] div_frac;
   } tick_cfg_t;

endpackage

// File: rtl/tick_subdiv.sv
// One sub-tick channel: counts main terminals and pulses once every div_i+1.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : restart (disable or sync), counter forced to 0
//   adv_i         : main terminal, advance the counter
//   div_i         : divider M, sampled live at each advance
//   tick_o        : registered pulse, coincident with the main tick
module tick_subdiv #(
   parameter int SUB_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             adv_i,
   input  logic [SUB_W-1:0] div_i,
   output logic             tick_o
);

   logic [SUB_W-1:0] scnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scnt   <= '0;
         tick_o <= 1'b0;
      end else if (clr_i) begin
         scnt   <= '0;
         tick_o <= 1'b0;
      end else if (adv_i) begin
         // >= so that lowering M below the running count wraps immediately
         if (scnt >= div_i) begin
            scnt   <= '0;
            tick_o <= 1'b1;
         end else begin
            scnt   <= scnt + SUB_W'(1);
            tick_o <= 1'b0;
         end
      end else begin
         tick_o <= 1'b0;
      end
   end

endmodule

// File: rtl/tick_gen_frac.sv
// Programmable fractional-N tick generator with NUM_SUB derived sub-ticks.
//   clk_i, rst_ni           : clock, async active-low reset
//   en_i                    : enable; low holds all phase state at 0
//   sync_i                  : phase restart pulse
//   cfg_we_i                : load div_int_i/div_frac_i into the shadow
//   div_int_i, div_frac_i   : integer N and fractional F of the period
//   cfg_pend_o              : shadow loaded but not yet applied
//   sub_div_i               : per-channel sub divider M[k]
//   tick_o, sub_tick_o      : registered one-cycle pulses
// Average period is N + 1 + F/2^FRAC_W cycles. DIV_W/FRAC_W must match the
// package widths, since tick_cfg_t carries the config fields.
module tick_gen_frac
   import tick_pkg::*;
#(
   parameter int DIV_W       = tick_pkg::DIV_W,
   parameter int FRAC_W      = tick_pkg::FRAC_W,
   parameter int DEFAULT_DIV = tick_pkg::DEFAULT_DIV,
   parameter int NUM_SUB     = 2,
   parameter int SUB_W       = tick_pkg::SUB_W
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     en_i,
   input  logic                     sync_i,
   input  logic                     cfg_we_i,
   input  logic [DIV_W-1:0]         div_int_i,
   input  logic [FRAC_W-1:0]        div_frac_i,
   output logic                     cfg_pend_o,
   input  logic [NUM_SUB*SUB_W-1:0] sub_div_i,
   output logic                     tick_o,
   output logic [NUM_SUB-1:0]       sub_tick_o
);

   // cnt is one bit wider than N: the extended terminal N+1 must fit
   logic [DIV_W:0]  cnt;
   logic [FRAC_W-1:0] acc;
   logic              ext;
   tick_cfg_t         active_q, shadow_q;
   logic              pend_q;

   logic [DIV_W:0]  term_cnt;
   logic [FRAC_W:0] acc_sum;
   logic            terminal, clr, apply;

   assign term_cnt = {1'b0, active_q.div_int} + (DIV_W+1)'(ext);
   assign acc_sum  = {1'b0, acc} + {1'b0, active_q.div_frac};
   assign clr      = !en_i || sync_i;
   // sync beats terminal: no tick on a sync cycle
   assign terminal = en_i && !sync_i && (cnt == term_cnt);
   assign apply    = pend_q && (clr || terminal);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt    <= '0;
         acc    <= '0;
         ext    <= 1'b0;
         tick_o <= 1'b0;
      end else if (clr) begin
         cnt    <= '0;
         acc    <= '0;
         ext    <= 1'b0;
         tick_o <= 1'b0;
      end else if (terminal) begin
         cnt    <= '0;
         acc    <= acc_sum[FRAC_W-1:0];
         ext    <= acc_sum[FRAC_W];   // carry stretches the next period by one
         tick_o <= 1'b1;
      end else begin
         cnt    <= cnt + (DIV_W+1)'(1);
         tick_o <= 1'b0;
      end
   end

   // Apply uses the shadow as it was before this cycle's write, so a write
   // coinciding with a boundary lands in the shadow and waits for the next one.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active_q <= '{div_int: DIV_W'(DEFAULT_DIV), div_frac: '0};
         shadow_q <= '0;
         pend_q   <= 1'b0;
      end else begin
         if (apply)    active_q <= shadow_q;
         if (cfg_we_i) shadow_q <= '{div_int: div_int_i, div_frac: div_frac_i};
         if (cfg_we_i)   pend_q <= 1'b1;
         else if (apply) pend_q <= 1'b0;
      end
   end

   assign cfg_pend_o = pend_q;

   for (genvar k = 0; k < NUM_SUB; k++) begin : g_sub
      tick_subdiv #(.SUB_W(SUB_W)) u_sub (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .clr_i  (clr),
         .adv_i  (terminal),
         .div_i  (sub_div_i[k*SUB_W +: SUB_W]),
         .tick_o (sub_tick_o[k])
      );
   end

endmodule

// File: tb/tb_tick_gen_frac.sv
module tb_tick_gen_frac;

   localparam int DIV_W = 10, FRAC_W = 8, NUM_SUB = 2, SUB_W = 8;

   logic                     clk_i = 1'b0;
   logic                     rst_ni = 1'b0;
   logic                     en_i = 1'b0;
   logic                     sync_i = 1'b0;
   logic                     cfg_we_i = 1'b0;
   logic [DIV_W-1:0]         div_int_i = '0;
   logic [FRAC_W-1:0]        div_frac_i = '0;
   logic                     cfg_pend_o;
   logic [NUM_SUB*SUB_W-1:0] sub_div_i = '1;
   logic                     tick_o;
   logic [NUM_SUB-1:0]       sub_tick_o;

   tick_gen_frac #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .DEFAULT_DIV(999),
                   .NUM_SUB(NUM_SUB), .SUB_W(SUB_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .sync_i(sync_i),
      .cfg_we_i(cfg_we_i), .div_int_i(div_int_i), .div_frac_i(div_frac_i),
      .cfg_pend_o(cfg_pend_o), .sub_div_i(sub_div_i), .tick_o(tick_o),
      .sub_tick_o(sub_tick_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0, n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: edges remaining until the next tick, fractional phase
   // as an integer sum mod 2^FRAC_W, and ticks seen since each sub-tick.
   int m_rem, m_frac, m_n, m_f, s_n, s_f;
   bit m_pend;
   int m_since[NUM_SUB];
   bit exp_tick;
   bit [NUM_SUB-1:0] exp_sub;
   int cyc_cnt, first_tick;

   task automatic model_reset();
      m_n = 999; m_f = 0; s_n = 0; s_f = 0; m_pend = 0; m_frac = 0;
      m_rem = m_n + 1;
      for (int k = 0; k < NUM_SUB; k++) m_since[k] = 0;
      exp_tick = 0; exp_sub = '0;
      cyc_cnt = 0; first_tick = -1;
   endtask

   task automatic model_step();
      int carry, mk;
      exp_tick = 0; exp_sub = '0;
      if (!en_i || sync_i) begin
         if (m_pend) begin m_n = s_n; m_f = s_f; m_pend = 0; end
         m_frac = 0;
         for (int k = 0; k < NUM_SUB; k++) m_since[k] = 0;
         m_rem = m_n + 1;
      end else begin
         m_rem--;
         if (m_rem == 0) begin
            exp_tick = 1;
            carry  = (m_frac + m_f) >= (1 << FRAC_W) ? 1 : 0;
            m_frac = (m_frac + m_f) % (1 << FRAC_W);
            for (int k = 0; k < NUM_SUB; k++) begin
               mk = int'(sub_div_i[k*SUB_W +: SUB_W]);
               if (m_since[k] >= mk) begin exp_sub[k] = 1; m_since[k] = 0; end
               else m_since[k]++;
            end
            if (m_pend) begin m_n = s_n; m_f = s_f; m_pend = 0; end
            m_rem = m_n + carry + 1;
         end
      end
      if (cfg_we_i) begin s_n = int'(div_int_i); s_f = int'(div_frac_i); m_pend = 1; end
   endtask

   // One clock: model the edge, sample 1 time unit later, drop pulses.
   task automatic cyc(input string tag);
      @(posedge clk_i);
      model_step();
      cyc_cnt++;
      #1;
      if (tick_o && first_tick < 0) first_tick = cyc_cnt;
      chk({tag, ".tick"}, int'(tick_o), int'(exp_tick));
      chk({tag, ".sub"},  int'(sub_tick_o), int'(exp_sub));
      chk({tag, ".pend"}, int'(cfg_pend_o), int'(m_pend));
      cfg_we_i = 1'b0;
      sync_i   = 1'b0;
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag);
   endtask

   task automatic cfg(input int n, input int f);
      cfg_we_i = 1'b1; div_int_i = DIV_W'(n); div_frac_i = FRAC_W'(f);
   endtask

   initial begin
      model_reset();
      en_i = 1'b1;
      sub_div_i = {8'hFF, 8'hFF};
      #2;
      chk("rst.tick", int'(tick_o), 0);
      chk("rst.sub",  int'(sub_tick_o), 0);
      chk("rst.pend", int'(cfg_pend_o), 0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // default 1000-cycle period
      run("dflt", 2100);
      chk("first_tick_cycle", first_tick, 1000);

      // mid-period write of N=9, waits for the 1000-cycle boundary
      cfg(9, 0);
      run("n9", 950);

      // N=3, F=0x80: 4,4,5,4,5...
      cfg(3, 8'h80);
      run("frac", 60);

      // sub channels M0=0, M1=2 with N=1
      sub_div_i = {8'd2, 8'd0};
      cfg(1, 0);
      run("sub", 40);

      // sync landing exactly on a terminal, N=4
      cfg(4, 0);
      run("n4", 12);
      for (int i = 0; i < 20 && m_rem != 1; i++) cyc("n4w");
      chk("sync_align", m_rem, 1);
      sync_i = 1'b1;
      cyc("sync");
      run("postsync", 12);

      // enable drop with config pending
      cfg(6, 0);
      cyc("dis0");
      en_i = 1'b0;
      run("dis", 3);
      en_i = 1'b1;
      run("reen", 30);

      // async reset while tick_o is high (N=0 ticks every cycle)
      cfg(0, 0);
      run("n0", 6);
      for (int i = 0; i < 5 && !exp_tick; i++) cyc("n0w");
      chk("pre_rst_tick", int'(tick_o), 1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst.tick", int'(tick_o), 0);
      chk("arst.sub",  int'(sub_tick_o), 0);
      chk("arst.pend", int'(cfg_pend_o), 0);
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      cfg(2, 8'h40);
      run("post_rst", 20);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         en_i   = ($urandom_range(0, 49) != 0);
         sync_i = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 29) == 0) cfg($urandom_range(0, 7), $urandom_range(0, 255));
         if ($urandom_range(0, 59) == 0)
            sub_div_i = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
         cyc("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
